dma_arbiter: RTL

Arbitrates up to four DMA-capable peripherals (disk/tape controllers) that share the single 18-bit DMA port of the mc1201-class processor boards (`dma_req`/`dma_ack`/`dma_adr18`/`dma_stb`). It sits between the peripheral controllers and the processor board. It selects one owner by round-robin and runs the board-level request/acknowledge handshake. It multiplexes the owner's Wishbone master signals onto the shared bus and routes the acknowledge back to the owner. A bus watchdog terminates transfers that receive no acknowledge.

---
 rtl/dma_arb_pkg.sv | 18 +
 rtl/dma_arbiter_rr_pick.sv | 36 +++
 rtl/dma_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA arbiter: FSM encoding and the widths of the
// per-device packed buses.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_OWN  = 2'd2,
        ST_REL  = 2'd3
    } arb_state_t;

    localparam int ADR_W = 18;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;
    localparam int PTR_W = 2;
    localparam int WDG_W = 8;

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request at or
// after ptr, wrapping at NREQ-1 back to 0.
module rr_pick
    import dma_arb_pkg::*;
#(
    parameter int NREQ = 4
)(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = (int'(ptr) + gi >= NREQ) ? PTR_W'(int'(ptr) + gi - NREQ)
                                                       : PTR_W'(int'(ptr) + gi);
        end
    endgenerate

    // Scan from the far end so the candidate nearest ptr is written last and wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin owner of the shared 18-bit DMA port: board req/ack handshake,
// Wishbone muxing towards memory and an unacknowledged-strobe watchdog.
module dma_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO  = 255
)(
    input  logic                    clk_p,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    output logic [NREQ-1:0]         gnt_o,
    input  logic [NREQ*ADR_W-1:0]   adr18_i,
    input  logic [NREQ-1:0]         stb_i,
    input  logic [NREQ-1:0]         we_i,
    input  logic [NREQ*SEL_W-1:0]   sel_i,
    input  logic [NREQ*DAT_W-1:0]   dat_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [NREQ-1:0]         err_o,
    output logic                    dma_req,
    input  logic                    dma_ack,
    output logic [ADR_W-1:0]        dma_adr18,
    output logic                    dma_stb,
    output logic                    dma_we,
    output logic [SEL_W-1:0]        dma_sel,
    output logic [DAT_W-1:0]        dma_dat,
    input  logic                    bus_ack,
    input  logic                    bus_reset
);

    arb_state_t       state_reg;
    logic [PTR_W-1:0] owner_reg;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [WDG_W-1:0] wdog_reg;
    logic             tmo_block_reg;
    logic             dma_req_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [NREQ-1:0]  err_reg;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [PTR_W-1:0] owner_next;
    logic             in_own;
    logic             owner_req;
    logic             owner_stb;

    logic [ADR_W-1:0] adr_arr [NREQ];
    logic [SEL_W-1:0] sel_arr [NREQ];
    logic [DAT_W-1:0] dat_arr [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_i),
        .ptr (rr_ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dev
            assign adr_arr[gi] = adr18_i[gi*ADR_W +: ADR_W];
            assign sel_arr[gi] = sel_i[gi*SEL_W +: SEL_W];
            assign dat_arr[gi] = dat_i[gi*DAT_W +: DAT_W];
            // Memory latency passes straight through to the owner.
            assign ack_o[gi]   = dma_stb & bus_ack & (owner_reg == PTR_W'(gi));
        end
    endgenerate

    assign in_own     = (state_reg == ST_OWN);
    assign owner_req  = req_i[owner_reg];
    assign owner_stb  = stb_i[owner_reg];
    assign owner_next = (owner_reg == PTR_W'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

    assign dma_stb   = in_own & owner_stb & ~tmo_block_reg;
    assign dma_adr18 = in_own ? adr_arr[owner_reg] : '0;
    assign dma_we    = in_own & we_i[owner_reg];
    assign dma_sel   = in_own ? sel_arr[owner_reg] : '0;
    assign dma_dat   = in_own ? dat_arr[owner_reg] : '0;

    assign gnt_o   = gnt_reg;
    assign err_o   = err_reg;
    assign dma_req = dma_req_reg;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            wdog_reg      <= '0;
            tmo_block_reg <= 1'b0;
            dma_req_reg   <= 1'b0;
            gnt_reg       <= '0;
            err_reg       <= '0;
        end else begin
            err_reg <= '0;
            if (bus_reset) begin
                state_reg     <= ST_REL;
                gnt_reg       <= '0;
                dma_req_reg   <= 1'b0;
                wdog_reg      <= '0;
                tmo_block_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (pick_any) begin
                            state_reg   <= ST_ARB;
                            owner_reg   <= pick_idx;
                            dma_req_reg <= 1'b1;
                        end
                    end
                    ST_ARB: begin
                        if (!owner_req) begin
                            state_reg   <= ST_REL;
                            dma_req_reg <= 1'b0;
                        end else if (dma_ack) begin
                            state_reg <= ST_OWN;
                            gnt_reg   <= NREQ'(1) << owner_reg;
                        end
                    end
                    ST_OWN: begin
                        if (!owner_req && !owner_stb) begin
                            state_reg     <= ST_REL;
                            gnt_reg       <= '0;
                            dma_req_reg   <= 1'b0;
                            rr_ptr_reg    <= owner_next;
                            wdog_reg      <= '0;
                            tmo_block_reg <= 1'b0;
                        end else if (tmo_block_reg) begin
                            // Counter stays saturated until the owner ends the strobe.
                            if (!owner_stb) begin
                                tmo_block_reg <= 1'b0;
                                wdog_reg      <= '0;
                            end
                        end else if (dma_stb && !bus_ack) begin
                            if (wdog_reg == WDG_W'(TMO - 1)) begin
                                wdog_reg      <= WDG_W'(TMO);
                                tmo_block_reg <= 1'b1;
                                err_reg       <= NREQ'(1) << owner_reg;
                            end else begin
                                wdog_reg <= wdog_reg + 1'b1;
                            end
                        end else begin
                            wdog_reg <= '0;
                        end
                    end
                    ST_REL: begin
                        if (!dma_ack) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
